// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Baud divisor: the bit-period counter runs 0..result, so it is one less
  // than the number of clocks per bit.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz / baud) - 1;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receive-side consumer handshake: show-ahead word plus valid/ready and overrun.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_overrun;

  modport master (
    output rx_data, rx_frame_err, rx_parity_err, rx_valid, rx_overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_frame_err, rx_parity_err, rx_valid, rx_overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO. A push while full is only accepted when a pop
// happens on the same edge; otherwise it is dropped and the caller reports it.
// The head output reads as zero while empty so nothing stale leaks out.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchroniser, mid-bit sampling FSM and a
// show-ahead word FIFO with overrun reporting.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   RX_IDLE   | line idle, waiting for a 1->0 edge on rx_s
//   RX_START  | confirm start bit at mid-bit, else reject as glitch
//   RX_DATA   | shift DATA_BITS samples in LSB first
//   RX_PARITY | sample parity bit and record mismatch
//   RX_STOP   | sample STOP_BITS stop bits, push word after the last
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clock,
  input logic           reset,
  input logic           RxD,
  uart_rx_cfg_if.master rx_if
);

  localparam int DIV   = baud_div(CLK_HZ, BAUD);
  localparam int HALF  = DIV / 2;
  localparam int CW    = $clog2(DIV + 1);
  localparam int WIDTH = DATA_BITS + 2;
  localparam logic [CW-1:0] DIV_C  = CW'(DIV);
  localparam logic [CW-1:0] HALF_C = CW'(HALF);

  if (DATA_BITS < 5 || DATA_BITS > 16 ||
      PARITY < PAR_NONE || PARITY > PAR_ODD ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      DIV < 3) begin : g_bad_params
    $error("uart_rx_cfg: illegal parameter combination");
  end

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic                 sync1_q, rx_s_q, rx_prev_q;
  logic                 overrun_q, overrun_d;
  logic                 sample, push, pop;
  logic                 fifo_empty, fifo_full;
  logic [WIDTH-1:0]     push_word, head_word;

  assign sample = (cnt_q == HALF_C);

  // Two-flop synchroniser plus one delayed copy for falling-edge detection;
  // all reset high so a released reset never looks like a start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= RxD;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Next-state, sampling and push decisions.
  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == DIV_C) ? '0 : cnt_q + CW'(1);
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    push       = 1'b0;
    push_word  = {shift_q, frm_err_q | !rx_s_q, par_err_q};
    case (state_q)
      RX_IDLE: begin
        cnt_d      = '0;
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
        par_err_d  = 1'b0;
        frm_err_d  = 1'b0;
        if (rx_prev_q && !rx_s_q) state_d = RX_START;
      end
      RX_START: begin
        if (sample) state_d = rx_s_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (sample) begin
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'(DATA_BITS - 1))
            state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (sample) begin
          // Even parity wants an overall XOR of 0, odd wants 1.
          par_err_d = (^shift_q) ^ rx_s_q ^ (PARITY == PAR_ODD);
          state_d   = RX_STOP;
        end
      end
      RX_STOP: begin
        if (sample) begin
          if (!rx_s_q) frm_err_d = 1'b1;
          stop_cnt_d = 1'b1;
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            push    = 1'b1;
            state_d = RX_IDLE;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // FSM, timing and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
    end
  end

  assign pop       = !fifo_empty && rx_if.rx_ready;
  assign overrun_d = push && fifo_full && !pop;

  // Overrun is registered into a single-cycle pulse after the dropped push.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) overrun_q <= 1'b0;
    else        overrun_q <= overrun_d;
  end

  uart_rx_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (pop),
    .rdata_o (head_word),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign rx_if.rx_data       = head_word[WIDTH-1:2];
  assign rx_if.rx_frame_err  = head_word[1];
  assign rx_if.rx_parity_err = head_word[0];
  assign rx_if.rx_valid      = !fifo_empty;
  assign rx_if.rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three receiver configurations share one
// clock; frames are built from their field values, expected words are queued
// when a frame is launched and popped by a monitor whenever a word is taken.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int CLK_HZ = 160000;
  localparam int BAUD   = 10000;
  localparam int BT     = CLK_HZ / BAUD;  // clocks per bit
  localparam int HALF   = (BT - 1) / 2;

  // Per-instance configuration: A = 8N1/4, B = 16E2/2, C = 5O1/2.
  localparam int NB  [3] = '{8, 16, 5};
  localparam int PM  [3] = '{0, 1, 2};
  localparam int NS  [3] = '{1, 2, 1};
  localparam int DEP [3] = '{4, 2, 2};

  typedef struct packed {
    logic [15:0] d;
    logic        fe;
    logic        pe;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] rxd = 3'b111;
  logic [2:0] stall = 3'b000;
  logic [2:0] force_rdy = 3'b000;
  logic [2:0] rnd_rdy = 3'b000;

  exp_t q [3][$];
  int   ov_exp [3];
  int   ov_seen [3];
  int   cmp = 0;
  int   err = 0;
  int   cyc = 0;
  int   rise_cyc = -1;
  logic va_prev = 1'b0;

  always #5 clock = ~clock;

  uart_rx_cfg_if #(.DATA_BITS(8))  if_a ();
  uart_rx_cfg_if #(.DATA_BITS(16)) if_b ();
  uart_rx_cfg_if #(.DATA_BITS(5))  if_c ();

  assign if_a.rx_ready = stall[0] ? force_rdy[0] : rnd_rdy[0];
  assign if_b.rx_ready = stall[1] ? force_rdy[1] : rnd_rdy[1];
  assign if_c.rx_ready = stall[2] ? force_rdy[2] : rnd_rdy[2];

  uart_rx_cfg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_a (.clock(clock), .reset(reset), .RxD(rxd[0]), .rx_if(if_a.master));
  uart_rx_cfg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(16), .PARITY(1),
                .STOP_BITS(2), .FIFO_DEPTH(2))
    dut_b (.clock(clock), .reset(reset), .RxD(rxd[1]), .rx_if(if_b.master));
  uart_rx_cfg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(5), .PARITY(2),
                .STOP_BITS(1), .FIFO_DEPTH(2))
    dut_c (.clock(clock), .reset(reset), .RxD(rxd[2]), .rx_if(if_c.master));

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial forever begin
    @(posedge clock);
    #1;
    rnd_rdy = 3'($urandom);
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mon(input int i, input logic v, input logic r, input logic [15:0] d,
                     input logic fe, input logic pe, input logic ov);
    exp_t e;
    if (ov) ov_seen[i]++;
    if (v && r) begin
      if (q[i].size() == 0) begin
        cmp++;
        err++;
        $display("FAIL word%0d: got unexpected word %h/%b%b expected none", i, d, fe, pe);
      end else begin
        e = q[i].pop_front();
        check($sformatf("word%0d", i), {14'd0, d, fe, pe}, {14'd0, e.d, e.fe, e.pe});
      end
    end
  endtask

  // Monitor: a word is consumed on the next edge whenever valid and ready
  // are both high at the falling edge.
  always @(negedge clock) begin
    if (reset) begin
      mon(0, if_a.rx_valid, if_a.rx_ready, 16'(if_a.rx_data), if_a.rx_frame_err,
          if_a.rx_parity_err, if_a.rx_overrun);
      mon(1, if_b.rx_valid, if_b.rx_ready, if_b.rx_data, if_b.rx_frame_err,
          if_b.rx_parity_err, if_b.rx_overrun);
      mon(2, if_c.rx_valid, if_c.rx_ready, 16'(if_c.rx_data), if_c.rx_frame_err,
          if_c.rx_parity_err, if_c.rx_overrun);
      if (if_a.rx_valid && !va_prev) rise_cyc = cyc;
      va_prev = if_a.rx_valid;
    end
  end

  // Launch one frame on instance i. stops[k] is the level driven for stop
  // bit k. The last stop sample lands on edge push_cyc: two synchroniser
  // flops and the edge-detect register (3 edges), one edge into START with
  // the counter at 0, HALF more to the centre of the start bit, then one bit
  // time per remaining bit. With pop_at_push the consumer is made ready for
  // exactly the cycle ending on that edge.
  task automatic send(input int i, input logic [15:0] data, input bit flip,
                      input bit [1:0] stops, input bit pop_at_push, input bit expect_word,
                      output int push_cyc);
    bit          bits[$];
    exp_t        e;
    logic [31:0] mask;
    logic [15:0] dm;
    int          t0, p;
    mask = (32'h1 << NB[i]) - 32'h1;
    dm   = data & mask[15:0];
    e.d  = dm;
    e.pe = (PM[i] != 0) && flip;
    e.fe = 1'b0;
    bits.push_back(1'b0);
    for (int k = 0; k < NB[i]; k++) bits.push_back(dm[k]);
    if (PM[i] != 0) bits.push_back((^dm) ^ (PM[i] == 2) ^ flip);
    for (int k = 0; k < NS[i]; k++) begin
      bits.push_back(stops[k]);
      if (!stops[k]) e.fe = 1'b1;
    end
    if (expect_word) begin
      if (q[i].size() >= DEP[i] && !pop_at_push) ov_exp[i]++;
      else q[i].push_back(e);
    end
    p = 4 + HALF + (bits.size() - 1) * BT;
    @(posedge clock);
    #1;
    t0 = cyc;
    push_cyc = t0 + p;
    foreach (bits[b]) begin
      rxd[i] = bits[b];
      repeat (BT) begin
        if (pop_at_push) force_rdy[i] = (cyc - t0 == p - 1);
        @(posedge clock);
        #1;
      end
    end
    force_rdy[i] = 1'b0;
    rxd[i] = 1'b1;
    repeat (BT) @(posedge clock);
    #1;
  endtask

  task automatic wait_drain(input string nm);
    int left;
    for (int k = 0; k < 3000; k++) begin
      left = q[0].size() + q[1].size() + q[2].size();
      if (left == 0) break;
      @(posedge clock);
    end
    #1;
    left = q[0].size() + q[1].size() + q[2].size();
    check(nm, left, 0);
  endtask

  initial begin
    int  pc;
    bit  seen_valid;
    logic [15:0] dat;
    bit [1:0] st;
    int  inst;

    repeat (5) @(posedge clock);
    #1;
    check("reset_a", {if_a.rx_valid, if_a.rx_overrun, if_a.rx_frame_err,
                      if_a.rx_parity_err, 8'(if_a.rx_data)}, 0);
    check("reset_b", {if_b.rx_valid, if_b.rx_overrun, if_b.rx_frame_err,
                      if_b.rx_parity_err, if_b.rx_data}, 0);
    check("reset_c", {if_c.rx_valid, if_c.rx_overrun, if_c.rx_frame_err,
                      if_c.rx_parity_err, 5'(if_c.rx_data)}, 0);
    reset = 1'b1;
    repeat (3 * BT) @(posedge clock);

    // 8N1 0xA5 and its latency from line edge to rx_valid.
    rise_cyc = -1;
    send(0, 16'hA5, 1'b0, 2'b11, 1'b0, 1'b1, pc);
    check("latency_a", rise_cyc, pc);
    wait_drain("drain_a5");

    // 16-bit even parity: good parity, then flipped.
    send(1, 16'h1234, 1'b0, 2'b11, 1'b0, 1'b1, pc);
    send(1, 16'h1234, 1'b1, 2'b11, 1'b0, 1'b1, pc);
    wait_drain("drain_par");

    // Short low glitch on an idle line must be rejected.
    seen_valid = 1'b0;
    @(posedge clock);
    #1;
    rxd[0] = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    rxd[0] = 1'b1;
    repeat (3 * BT) begin
      @(negedge clock);
      if (if_a.rx_valid) seen_valid = 1'b1;
    end
    check("glitch_valid", 32'(seen_valid), 0);
    send(0, 16'h3C, 1'b0, 2'b11, 1'b0, 1'b1, pc);
    wait_drain("drain_3c");

    // Second stop bit low, then a clean frame to show resync.
    send(1, 16'h0055, 1'b0, 2'b01, 1'b0, 1'b1, pc);
    send(1, 16'h9A6B, 1'b0, 2'b11, 1'b0, 1'b1, pc);
    // Odd parity, 5-bit words.
    send(2, 16'h0015, 1'b0, 2'b11, 1'b0, 1'b1, pc);
    send(2, 16'h000C, 1'b1, 2'b11, 1'b0, 1'b1, pc);
    wait_drain("drain_misc");

    // Overrun: consumer stalled, five words into a depth-4 FIFO.
    stall[0] = 1'b1;
    for (int k = 1; k <= 4; k++) send(0, 16'(k), 1'b0, 2'b11, 1'b0, 1'b1, pc);
    check("ovr_before5", ov_seen[0], ov_exp[0]);
    send(0, 16'h05, 1'b0, 2'b11, 1'b0, 1'b1, pc);
    check("ovr_after5", ov_seen[0], ov_exp[0]);
    stall[0] = 1'b0;
    wait_drain("drain_ovr");

    // Full FIFO with push and pop on the same edge: both happen, no overrun.
    stall[1] = 1'b1;
    send(1, 16'hBEEF, 1'b0, 2'b11, 1'b0, 1'b1, pc);
    send(1, 16'h0F0F, 1'b0, 2'b11, 1'b0, 1'b1, pc);
    send(1, 16'hC3A5, 1'b0, 2'b11, 1'b1, 1'b1, pc);
    check("ovr_pushpop", ov_seen[1], ov_exp[1]);
    stall[1] = 1'b0;
    wait_drain("drain_pp");

    // Reset during the 4th data bit of 0xFF, then a clean 0x81.
    @(posedge clock);
    #1;
    rxd[0] = 1'b0;
    repeat (BT) @(posedge clock);
    #1;
    rxd[0] = 1'b1;
    repeat (3 * BT + BT / 2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    check("reset_mid_a", {if_a.rx_valid, if_a.rx_overrun, if_a.rx_frame_err,
                          if_a.rx_parity_err, 8'(if_a.rx_data)}, 0);
    reset = 1'b1;
    repeat (2 * BT) @(posedge clock);
    send(0, 16'h81, 1'b0, 2'b11, 1'b0, 1'b1, pc);
    wait_drain("drain_81");

    // Randomized frames across all instances with random error injection.
    for (int n = 0; n < 30; n++) begin
      inst  = int'($urandom_range(2));
      dat   = 16'($urandom);
      st[0] = ($urandom_range(3) != 0);
      st[1] = ($urandom_range(3) != 0);
      send(inst, dat, ($urandom_range(3) == 0), st, 1'b0, 1'b1, pc);
    end
    wait_drain("drain_rand");

    for (int i = 0; i < 3; i++) check($sformatf("ovr_total%0d", i), ov_seen[i], ov_exp[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameter CLK_HZ, default 27000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame, legal 5..16.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 Parameter STOP_BITS, default 1, stop bits checked per frame, legal 1..2.
REQ-006 Parameter FIFO_DEPTH, default 4, receive FIFO depth, power of two, at least 2.
REQ-007 clock  in  1  sole clock; all logic on its rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 RxD  in  1  serial line, asynchronous to clock, idle high.
REQ-010 rx_data  out  DATA_BITS  FIFO head word, LSB = first data bit received.
REQ-011 rx_frame_err  out  1  head word had at least one stop bit sampled 0.
REQ-012 rx_parity_err  out  1  head word failed parity check; always 0 when PARITY=0.
REQ-013 rx_valid  out  1  FIFO non-empty; head outputs valid.
REQ-014 rx_ready  in  1  consumer accepts head word.
REQ-015 rx_overrun  out  1  one-cycle pulse when a completed word is dropped.

Function
REQ-016 RxD shall pass through a 2-flop synchroniser; all decisions use the synchronised value rx_s.
REQ-017 DIV = CLK_HZ/BAUD - 1 and HALF = DIV/2 (integer division); baud counter width = $clog2(DIV+1); counter counts 0..DIV and wraps to 0.
REQ-018 States: IDLE, START, DATA, PARITY, STOP; the baud counter is cleared on the IDLE->START transition.
REQ-019 IDLE: when rx_s changes 1->0, go to START; otherwise hold.
REQ-020 START: at count == HALF, go to DATA if rx_s == 0; otherwise go to IDLE with no push (false-start rejection).
REQ-021 DATA: at each count == HALF, shift rx_s in LSB-first; after DATA_BITS samples, go to PARITY if PARITY != 0, else STOP.
REQ-022 PARITY: at HALF, sample rx_s; even mode errors if XOR(data, bit) = 1; odd mode errors if XOR(data, bit) = 0.
REQ-023 STOP: sample STOP_BITS times at HALF; any 0 sets frame_err; after the last stop sample, push {data, frame_err, parity_err} and go to IDLE on the same edge.
REQ-024 Frames with errors shall still be pushed, tagged with their error flags.
REQ-025 FIFO is show-ahead; rx_valid = not empty; a pop occurs on an edge where rx_valid && rx_ready.
REQ-026 Latency: rx_valid rises on the edge after the final stop sample when the FIFO was empty.
REQ-027 Push when full with no pop: drop the word, pulse rx_overrun for 1 cycle, keep FIFO contents unchanged.
REQ-028 Push and pop on the same edge when full: both shall occur; no overrun.
REQ-029 rx_ready with rx_valid=0 shall have no effect; pointers wrap modulo FIFO_DEPTH.
REQ-030 Illegal parameters (DATA_BITS, PARITY, STOP_BITS, FIFO_DEPTH out of range, or DIV < 3) shall cause an elaboration error.

Reset
REQ-031 While reset=0: state IDLE; counters, shift register and FIFO pointers 0; synchroniser flops 1.
REQ-032 While reset=0: rx_valid, rx_overrun, rx_frame_err, rx_parity_err and rx_data are 0.
REQ-033 Reset mid-frame shall discard the partial frame; no spurious start is detected after release while RxD is high.

Structure
REQ-034 Package uart_pkg shall hold the rx_state_t enum, the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and a divisor-calculation function.
REQ-035 The FIFO shall be a sub-module uart_rx_fifo (width DATA_BITS+2, depth FIFO_DEPTH, show-ahead); all other logic stays in uart_rx_cfg.

Verification
REQ-036 Defaults (DIV=2811): send 8N1 0xA5 -> one word rx_data=0xA5, both error flags 0, rx_valid 1 cycle after the stop sample.
REQ-037 DATA_BITS=16, PARITY=1: send 0x1234 with correct parity, then with flipped parity -> 0x1234 with parity_err=0, then 0x1234 with parity_err=1.
REQ-038 Low glitch of 500 cycles on idle line -> no push; rx_valid stays 0; next valid frame 0x3C is received correctly.
REQ-039 STOP_BITS=2, second stop bit driven 0, data 0x55 -> word 0x55 with frame_err=1; receiver resyncs on the next frame.
REQ-040 FIFO_DEPTH=4, rx_ready=0, send 0x01..0x05 -> rx_overrun pulses once, at the fifth push; draining yields 0x01..0x04 in order.
REQ-041 Assert reset during the 4th data bit of 0xFF, release, then send 0x81 -> exactly one word 0x81.
